reg_wb: RTL and testbench

Write-back end of the ALU result interface: owns the 16 x 16-bit general register file and the comparison flag register, and consumes the ALU's register-write and flag-write bundles. Serves operand reads to the ALU's data input and maintains a per-register pending-write scoreboard, so that decode can be stalled on read-after-write hazards. Sits between decode (read/issue requests) and the ALU (write-back), closing the pipeline loop.

---
 rtl/reg_wb_pkg.sv | 33 +++
 rtl/reg_wb_rf.sv | 37 +++
 rtl/reg_wb.sv | 61 ++++++
 tb/tb_reg_wb.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared ALU/write-back bundle types and register file defaults.
package reg_wb_pkg;
    localparam int DEF_NREG = 16;
    localparam int DEF_DW = 16;
    localparam int AW = 4;

    typedef struct packed {
        logic [DEF_DW-1:0] data;
        logic ena;
        logic [AW-1:0] adr;
    } signal_alu_wr_reg;

    typedef struct packed {
        logic bolshe;
        logic menshe;
        logic ravno;
        logic ena;
        logic rav_adr;
        logic ena_ra;
    } signal_flag_wr_alu;

    typedef struct packed {
        logic bolshe;
        logic menshe;
        logic ravno;
        logic rav_adr;
    } signal_flag_alu;

    typedef struct packed {
        logic [DEF_DW-1:0] a;
        logic [DEF_DW-1:0] b;
    } signal_data;
endpackage

// File: rtl/reg_wb_rf.sv
// reg_wb_rf: register array with two registered read ports.
// WB_BYPASS_EN forwards same-cycle write data to a matching read port.
module reg_wb_rf
    import reg_wb_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int DW = DEF_DW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_adr_a_i,
    input  logic [AW-1:0]    rd_adr_b_i,
    input  signal_alu_wr_reg wr_i,
    output signal_data       data_o
);
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] rd_a, rd_b;

`ifdef WB_BYPASS_EN
    assign rd_a = (wr_i.ena && wr_i.adr == rd_adr_a_i) ? wr_i.data : regs[rd_adr_a_i];
    assign rd_b = (wr_i.ena && wr_i.adr == rd_adr_b_i) ? wr_i.data : regs[rd_adr_b_i];
`else
    assign rd_a = regs[rd_adr_a_i];
    assign rd_b = regs[rd_adr_b_i];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            data_o <= '0;
        end else begin
            if (wr_i.ena) regs[wr_i.adr] <= wr_i.data;
            if (rd_en_i) data_o <= '{a: rd_a, b: rd_b};
        end
    end
endmodule

// File: rtl/reg_wb.sv
// reg_wb: write-back stage with register file, pending-write scoreboard and flags.
// WB_BYPASS_EN: a write resolving a pending register also clears its hazard in the same cycle.
module reg_wb
    import reg_wb_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int DW = DEF_DW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_adr_a_i,
    input  logic [AW-1:0]     rd_adr_b_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_adr_i,
    input  signal_alu_wr_reg  alu_wr_reg_i,
    input  signal_flag_wr_alu flag_wr_i,
    output signal_data        data_o,
    output signal_flag_alu    flag_o,
    output logic              haz_o,
    output logic [NREG-1:0]   busy_o
);
    logic [NREG-1:0] busy, set, clr, busy_eff;

    reg_wb_rf #(.NREG(NREG), .DW(DW)) u_rf (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .rd_en_i(rd_en_i),
        .rd_adr_a_i(rd_adr_a_i),
        .rd_adr_b_i(rd_adr_b_i),
        .wr_i(alu_wr_reg_i),
        .data_o(data_o)
    );

    assign set = iss_en_i ? NREG'(1) << iss_adr_i : '0;
    assign clr = alu_wr_reg_i.ena ? NREG'(1) << alu_wr_reg_i.adr : '0;
`ifdef WB_BYPASS_EN
    assign busy_eff = busy & ~clr;
`else
    assign busy_eff = busy;
`endif
    assign busy_o = busy;

    // set after clear: a newly issued writer to the same register stays outstanding
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy <= '0;
            haz_o <= 1'b0;
            flag_o <= '0;
        end else begin
            busy <= (busy & ~clr) | set;
            haz_o <= rd_en_i && (busy_eff[rd_adr_a_i] || busy_eff[rd_adr_b_i]);
            if (flag_wr_i.ena) begin
                flag_o.bolshe <= flag_wr_i.bolshe;
                flag_o.menshe <= flag_wr_i.menshe;
                flag_o.ravno <= flag_wr_i.ravno;
            end
            if (flag_wr_i.ena_ra) flag_o.rav_adr <= flag_wr_i.rav_adr;
        end
    end
endmodule

// File: tb/tb_reg_wb.sv
// tb_reg_wb: directed self-checking bench for reg_wb (honours WB_BYPASS_EN).
module tb_reg_wb;
    import reg_wb_pkg::*;

    logic clk = 0;
    logic rst, rd_en, iss_en;
    logic [3:0] adr_a, adr_b, iss_adr;
    signal_alu_wr_reg wr;
    signal_flag_wr_alu fw;
    signal_data data;
    signal_flag_alu flag;
    logic haz;
    logic [15:0] busy;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    reg_wb dut (
        .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .rd_adr_a_i(adr_a), .rd_adr_b_i(adr_b),
        .iss_en_i(iss_en), .iss_adr_i(iss_adr), .alu_wr_reg_i(wr), .flag_wr_i(fw),
        .data_o(data), .flag_o(flag), .haz_o(haz), .busy_o(busy)
    );

    task automatic idle();
        rst = 0; rd_en = 0; iss_en = 0; adr_a = 0; adr_b = 0; iss_adr = 0;
        wr = '0; fw = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        wr = '{data: d, ena: 1'b1, adr: a};
    endtask

    task automatic read(input logic [3:0] a, input logic [3:0] b);
        rd_en = 1; adr_a = a; adr_b = b;
    endtask

    task automatic test_reset();
        rst = 1; tick();
        chk("rst_haz", 32'(haz), 0);
        write(3, 16'h1234); tick();
        rst = 1; tick();
        read(3, 3); tick();
        chk("rst_a", 32'(data.a), 0);
        chk("rst_b", 32'(data.b), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flag", 32'(flag), 0);
        rst = 1; write(9, 16'h9999); iss_en = 1; iss_adr = 9; tick();
        read(9, 9); tick();
        chk("rst_override_data", 32'(data.a), 0);
        chk("rst_override_busy", 32'(busy), 0);
    endtask

    task automatic test_write_read();
        write(5, 16'hBEEF); tick();
        read(5, 0); tick();
        chk("wr_a", 32'(data.a), 32'hBEEF);
        chk("wr_b", 32'(data.b), 0);
        chk("wr_haz", 32'(haz), 0);
        tick();
        chk("hold_a", 32'(data.a), 32'hBEEF);
    endtask

    task automatic test_hazard();
        iss_en = 1; iss_adr = 7; tick();
        tick();
        read(7, 0); tick();
        chk("haz_set", 32'(haz), 1);
        chk("haz_busy", 32'(busy), 32'h0080);
        write(7, 16'h0042); tick();
        chk("haz_rd_off", 32'(haz), 0);
        read(7, 0); tick();
        chk("haz_busy_clr", 32'(busy), 0);
        chk("haz_clr", 32'(haz), 0);
        chk("haz_data", 32'(data.a), 32'h0042);
    endtask

    task automatic test_same_cycle();
        write(2, 16'h0011); tick();
        iss_en = 1; iss_adr = 2; tick();
        write(2, 16'h00AA); read(2, 2); tick();
`ifdef WB_BYPASS_EN
        chk("byp_a", 32'(data.a), 32'h00AA);
        chk("byp_b", 32'(data.b), 32'h00AA);
        chk("byp_haz", 32'(haz), 0);
`else
        chk("nobyp_a", 32'(data.a), 32'h0011);
        chk("nobyp_b", 32'(data.b), 32'h0011);
        chk("nobyp_haz", 32'(haz), 1);
`endif
        read(2, 0); tick();
        chk("retry_a", 32'(data.a), 32'h00AA);
        chk("retry_haz", 32'(haz), 0);
    endtask

    task automatic test_issue_write();
        iss_en = 1; iss_adr = 4; write(4, 16'h5555); tick();
        chk("iw_busy", 32'(busy), 32'h0010);
        read(4, 5); tick();
        chk("iw_data", 32'(data.a), 32'h5555);
        chk("iw_haz", 32'(haz), 1);
        write(4, 16'h6666); tick();
        chk("iw_busy_clr", 32'(busy), 0);
    endtask

    task automatic test_back_to_back();
        read(5, 7); tick();
        chk("b2b_1a", 32'(data.a), 32'hBEEF);
        chk("b2b_1b", 32'(data.b), 32'h0042);
        read(4, 2); tick();
        chk("b2b_2a", 32'(data.a), 32'h6666);
        chk("b2b_2b", 32'(data.b), 32'h00AA);
    endtask

    task automatic test_flags();
        fw.ena = 1; fw.menshe = 1; tick();
        chk("flag_m", 32'(flag), 32'b0100);
        fw.ena_ra = 1; fw.rav_adr = 1; fw.bolshe = 1; tick();
        chk("flag_ra", 32'(flag), 32'b0101);
        fw.ena = 1; fw.ravno = 1; fw.ena_ra = 1; fw.rav_adr = 0; tick();
        chk("flag_both", 32'(flag), 32'b0010);
        rst = 1; tick();
        chk("flag_rst", 32'(flag), 0);
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_hazard();
        test_same_cycle();
        test_issue_write();
        test_back_to_back();
        test_flags();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
